// File: rtl/ieeedrv_pkg.sv
// Types and widths shared by the IEEE drive track logic and the SD request arbiter.
package ieeedrv_pkg;

    localparam int LBA_W     = 32;
    localparam int BLK_CNT_W = 6;
    localparam int BUF_W     = 8;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } sd_arb_st_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ieeedrv_sd_arb_if.sv
// Host-side SD request port: the arbiter is master, the host SD controller is slave.
interface ieeedrv_sd_arb_if;
    import ieeedrv_pkg::*;

    logic [LBA_W-1:0]     sd_lba;
    logic [BLK_CNT_W-1:0] sd_blk_cnt;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic                 sd_buff_wr;
    logic [BUF_W-1:0]     sd_buff_din;

    modport master (
        output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_wr
    );

endinterface

// File: rtl/ieeedrv_sd_arb_rr_pick.sv
// Round-robin search: first set bit of pending at or after start, wrapping modulo N.
module ieeedrv_rr_pick
    import ieeedrv_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!found && pending[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Merges per-subdrive SD request channels onto one host SD port, one transfer at a time,
// with round-robin fairness and an optional REQ-phase timeout.
module ieeedrv_sd_arb
    import ieeedrv_pkg::*;
#(
    parameter  int          NCH     = 2,
    parameter  logic [23:0] TIMEOUT = 24'hFFFFFF,
    localparam int          GW      = idx_w(NCH)
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [LBA_W-1:0]     ch_lba      [NCH],
    input  logic [BLK_CNT_W-1:0] ch_blk_cnt  [NCH],
    input  logic [NCH-1:0]       ch_rd,
    input  logic [NCH-1:0]       ch_wr,
    output logic [NCH-1:0]       ch_ack,
    input  logic [BUF_W-1:0]     ch_buff_din [NCH],
    output logic [NCH-1:0]       ch_buff_wr,
    ieeedrv_sd_arb_if.master     host,
    output logic                 busy,
    output logic [GW-1:0]        grant,
    output logic                 timeout
);

    sd_arb_st_t    state, state_nx;
    logic [GW-1:0] rr;
    logic [23:0]   to_cnt;
    logic [NCH-1:0] pending;
    logic          pick_found;
    logic [GW-1:0] pick_idx;

    logic latch_req;
    logic drop_strobe;
    logic rr_adv;
    logic to_fire;

    function automatic logic [GW-1:0] next_ch(input logic [GW-1:0] cur);
        if (NCH == 1 || int'(cur) >= NCH - 1)
            return '0;
        return cur + 1'b1;
    endfunction

    assign pending = ch_rd | ch_wr;

    ieeedrv_rr_pick #(.N(NCH)) u_pick (
        .pending (pending),
        .start   (rr),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        state_nx    = state;
        latch_req   = 1'b0;
        drop_strobe = 1'b0;
        rr_adv      = 1'b0;
        to_fire     = 1'b0;
        case (state)
            // Host may still be finishing a transfer begun before reset.
            ST_FLUSH: begin
                if (!host.sd_ack)
                    state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (pick_found) begin
                    latch_req = 1'b1;
                    state_nx  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (host.sd_ack) begin
                    drop_strobe = 1'b1;
                    state_nx    = ST_XFER;
                end else if (!pending[grant]) begin
                    drop_strobe = 1'b1;
                    rr_adv      = 1'b1;
                    state_nx    = ST_IDLE;
                end else if (TIMEOUT != 24'd0 && to_cnt == TIMEOUT - 24'd1) begin
                    drop_strobe = 1'b1;
                    rr_adv      = 1'b1;
                    to_fire     = 1'b1;
                    state_nx    = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!host.sd_ack) begin
                    rr_adv   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= ST_FLUSH;
            rr              <= '0;
            grant           <= '0;
            to_cnt          <= '0;
            busy            <= 1'b0;
            timeout         <= 1'b0;
            host.sd_rd      <= 1'b0;
            host.sd_wr      <= 1'b0;
            host.sd_lba     <= '0;
            host.sd_blk_cnt <= '0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx != ST_IDLE);
            timeout <= to_fire;
            if (latch_req) begin
                // Write wins when a channel raises both requests.
                grant           <= pick_idx;
                host.sd_lba     <= ch_lba[pick_idx];
                host.sd_blk_cnt <= ch_blk_cnt[pick_idx];
                host.sd_wr      <= ch_wr[pick_idx];
                host.sd_rd      <= ~ch_wr[pick_idx];
                to_cnt          <= '0;
            end else if (state == ST_REQ) begin
                to_cnt <= to_cnt + 24'd1;
                if (drop_strobe) begin
                    host.sd_rd <= 1'b0;
                    host.sd_wr <= 1'b0;
                end
            end
            if (rr_adv)
                rr <= next_ch(grant);
        end
    end

    always_comb begin
        ch_ack     = '0;
        ch_buff_wr = '0;
        if (state == ST_XFER) begin
            ch_ack[grant]     = host.sd_ack;
            ch_buff_wr[grant] = host.sd_buff_wr & host.sd_ack;
        end
    end

    assign host.sd_buff_din = ch_buff_din[grant];

endmodule
